// File: rtl/sys_seq_ctrl_if.sv
// Bus bundle between the system sequencer and its environment: program loader
// stream, core fetch/load-store taps, instruction/data memory ports and the dump stream.
interface sys_seq_ctrl_if #(
  parameter int unsigned WORD  = 32,
  parameter int unsigned ADDR  = 32,
  parameter int unsigned W_OPR = 32
);
  // program loader stream
  logic             ld_valid_i;
  logic             ld_ready_o;
  logic [WORD-1:0]  ld_data_i;
  logic             ld_last_i;
  // core side
  logic [ADDR-1:0]  core_inst_addr_i;
  logic             core_stall_o;
  logic             core_hlt_i;
  logic [ADDR-1:0]  core_ldst_addr_i;
  logic             core_ldst_write_i;
  logic [W_OPR-1:0] core_ldst_data_i;
  // instruction memory
  logic [ADDR-1:0]  imem_addr_o;
  logic             imem_write_o;
  logic [WORD-1:0]  imem_data_o;
  // data memory
  logic [ADDR-1:0]  dmem_addr_o;
  logic             dmem_write_o;
  logic [W_OPR-1:0] dmem_data_o;
  logic [W_OPR-1:0] dmem_q_i;
  // dump stream
  logic             dump_valid_o;
  logic             dump_ready_i;
  logic [W_OPR-1:0] dump_data_o;
  logic [ADDR-1:0]  dump_addr_o;
  logic             dump_last_o;
  // status
  logic [31:0]      cycles_o;
  logic             timeout_o;
  logic             done_o;

  // sequencer view
  modport slave (
    input  ld_valid_i, ld_data_i, ld_last_i,
    input  core_inst_addr_i, core_hlt_i, core_ldst_addr_i, core_ldst_write_i, core_ldst_data_i,
    input  dmem_q_i, dump_ready_i,
    output ld_ready_o, core_stall_o,
    output imem_addr_o, imem_write_o, imem_data_o,
    output dmem_addr_o, dmem_write_o, dmem_data_o,
    output dump_valid_o, dump_data_o, dump_addr_o, dump_last_o,
    output cycles_o, timeout_o, done_o
  );

  // environment view (loader, core, memories, dump sink)
  modport master (
    output ld_valid_i, ld_data_i, ld_last_i,
    output core_inst_addr_i, core_hlt_i, core_ldst_addr_i, core_ldst_write_i, core_ldst_data_i,
    output dmem_q_i, dump_ready_i,
    input  ld_ready_o, core_stall_o,
    input  imem_addr_o, imem_write_o, imem_data_o,
    input  dmem_addr_o, dmem_write_o, dmem_data_o,
    input  dump_valid_o, dump_data_o, dump_addr_o, dump_last_o,
    input  cycles_o, timeout_o, done_o
  );
endinterface

// File: rtl/sys_seq_ctrl.sv
// System sequencer: loads a program into instruction memory with the core stalled,
// runs the core until halt or cycle limit, then dumps data memory over a stream.
module sys_seq_ctrl #(
  parameter int unsigned WORD       = 32,
  parameter int unsigned ADDR       = 32,
  parameter int unsigned W_OPR      = 32,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DUMP_WORDS = 256,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input logic           clk,
  input logic           reset,
  sys_seq_ctrl_if.slave bus
);

  localparam int unsigned CYC_W = 32;

  typedef enum logic [2:0] {
    S_LOAD,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [ADDR-1:0]  r_ld_cnt, w_ld_cnt_nxt;
  logic [ADDR-1:0]  r_dump_ptr, w_dump_ptr_nxt;
  logic [CYC_W-1:0] r_cycles, w_cycles_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             r_ld_ready, r_stall, r_dump_valid, r_done;

  logic [ADDR-1:0]  w_imem_addr;
  logic             w_imem_write;
  logic [WORD-1:0]  w_imem_data;
  logic [ADDR-1:0]  w_dmem_addr;
  logic             w_dmem_write;
  logic [W_OPR-1:0] w_dmem_data;
  logic             w_ptr_last;

  assign w_ptr_last = (r_dump_ptr == ADDR'(DUMP_WORDS - 1));

  // State and counter registers; status flags are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_ld_cnt     <= '0;
      r_dump_ptr   <= '0;
      r_cycles     <= '0;
      r_timeout    <= 1'b0;
      r_ld_ready   <= 1'b1;
      r_stall      <= 1'b1;
      r_dump_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ld_cnt     <= w_ld_cnt_nxt;
      r_dump_ptr   <= w_dump_ptr_nxt;
      r_cycles     <= w_cycles_nxt;
      r_timeout    <= w_timeout_nxt;
      r_ld_ready   <= (w_state_nxt == S_LOAD);
      r_stall      <= (w_state_nxt != S_RUN);
      r_dump_valid <= (w_state_nxt == S_DUMP_OUT);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  // Next-state, counter updates and the memory port muxes
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_cnt_nxt   = r_ld_cnt;
    w_dump_ptr_nxt = r_dump_ptr;
    w_cycles_nxt   = r_cycles;
    w_timeout_nxt  = r_timeout;
    w_imem_addr    = '0;
    w_imem_write   = 1'b0;
    w_imem_data    = '0;
    w_dmem_addr    = r_dump_ptr;
    w_dmem_write   = 1'b0;
    w_dmem_data    = '0;

    case (r_state)
      S_LOAD: begin
        // ready is high for the whole phase, so every valid word is accepted
        w_imem_addr  = r_ld_cnt;
        w_imem_data  = bus.ld_data_i;
        w_imem_write = bus.ld_valid_i;
        if (bus.ld_valid_i) begin
          w_ld_cnt_nxt = r_ld_cnt + ADDR'(1);
          if (bus.ld_last_i || (r_ld_cnt == ADDR'(IMEM_DEPTH - 1))) begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        w_imem_addr  = bus.core_inst_addr_i;
        w_dmem_addr  = bus.core_ldst_addr_i;
        w_dmem_write = bus.core_ldst_write_i;
        w_dmem_data  = bus.core_ldst_data_i;
        w_cycles_nxt = r_cycles + CYC_W'(1);
        // halt takes priority over the cycle limit
        if (bus.core_hlt_i) begin
          w_state_nxt = S_DUMP_RD;
        end else if (r_cycles == CYC_W'(MAX_CYCLES - 1)) begin
          w_state_nxt   = S_DUMP_RD;
          w_timeout_nxt = 1'b1;
        end
      end
      S_DUMP_RD: begin
        w_state_nxt = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        if (bus.dump_ready_i) begin
          if (w_ptr_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_dump_ptr_nxt = r_dump_ptr + ADDR'(1);
            w_state_nxt    = S_DUMP_RD;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  assign bus.ld_ready_o   = r_ld_ready;
  assign bus.core_stall_o = r_stall;
  assign bus.imem_addr_o  = w_imem_addr;
  assign bus.imem_write_o = w_imem_write;
  assign bus.imem_data_o  = w_imem_data;
  assign bus.dmem_addr_o  = w_dmem_addr;
  assign bus.dmem_write_o = w_dmem_write;
  assign bus.dmem_data_o  = w_dmem_data;
  assign bus.dump_valid_o = r_dump_valid;
  assign bus.dump_data_o  = r_dump_valid ? bus.dmem_q_i : '0;
  assign bus.dump_addr_o  = r_dump_ptr;
  assign bus.dump_last_o  = r_dump_valid && w_ptr_last;
  assign bus.cycles_o     = r_cycles;
  assign bus.timeout_o    = r_timeout;
  assign bus.done_o       = r_done;

endmodule

// File: tb/tb_sys_seq_ctrl.sv
// Directed bench for sys_seq_ctrl with behavioural instruction/data memories.
module tb_sys_seq_ctrl;

  logic clk;
  logic reset;
  logic init_mem;
  int   checks;
  int   errors;

  logic [31:0] imem_m [0:255];
  logic [31:0] dmem_m [0:255];

  sys_seq_ctrl_if #(.WORD(32), .ADDR(32), .W_OPR(32)) bus_if ();

  sys_seq_ctrl #(
    .WORD(32), .ADDR(32), .W_OPR(32),
    .IMEM_DEPTH(256), .DUMP_WORDS(256), .MAX_CYCLES(50)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memories: synchronous write, registered read
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) begin
        dmem_m[i] <= 32'hD000_0000 | 32'(i);
        imem_m[i] <= '0;
      end
    end else begin
      if (bus_if.imem_write_o) imem_m[bus_if.imem_addr_o[7:0]] <= bus_if.imem_data_o;
      if (bus_if.dmem_write_o) dmem_m[bus_if.dmem_addr_o[7:0]] <= bus_if.dmem_data_o;
    end
    bus_if.dmem_q_i <= dmem_m[bus_if.dmem_addr_o[7:0]];
  end

  function automatic logic [31:0] exp_d(input int i);
    if (i == 7) return 32'hCAFE_BABE;
    return 32'hD000_0000 | 32'(i);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    init_mem = 1'b1;
    do_reset();
    init_mem = 1'b0;
    checks++; if (bus_if.ld_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ld_ready got %0b want 1", bus_if.ld_ready_o); end
    checks++; if (bus_if.core_stall_o !== 1'b1) begin errors++; $display("FAIL rst_stall got %0b want 1", bus_if.core_stall_o); end
    checks++; if (bus_if.done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %0b want 0", bus_if.done_o); end
    checks++; if (bus_if.dump_valid_o !== 1'b0) begin errors++; $display("FAIL rst_dump_valid got %0b want 0", bus_if.dump_valid_o); end
    checks++; if (bus_if.cycles_o !== 32'd0) begin errors++; $display("FAIL rst_cycles got %0d want 0", bus_if.cycles_o); end
    checks++; if (bus_if.timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0b want 0", bus_if.timeout_o); end
  endtask

  // three words with valid gaps, last on the third
  task automatic test_load_gaps();
    int unsigned vpat [6] = '{1, 0, 1, 0, 0, 1};
    int w;
    w = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus_if.ld_valid_i = (vpat[c] != 0);
      bus_if.ld_data_i  = 32'h1111_0000 + 32'(w);
      bus_if.ld_last_i  = (vpat[c] != 0) && (w == 2);
      #1;
      if (vpat[c] != 0) begin
        checks++; if (bus_if.imem_write_o !== 1'b1 || bus_if.imem_addr_o !== 32'(w)) begin
          errors++; $display("FAIL load_write w%0d got we=%0b a=%0d want we=1 a=%0d", w, bus_if.imem_write_o, bus_if.imem_addr_o, w); end
        w++;
      end else begin
        checks++; if (bus_if.imem_write_o !== 1'b0) begin errors++; $display("FAIL load_gap_write got %0b want 0", bus_if.imem_write_o); end
      end
    end
    @(negedge clk);
    bus_if.ld_valid_i = 1'b0;
    bus_if.ld_last_i  = 1'b0;
    #1;
    checks++; if (bus_if.core_stall_o !== 1'b0) begin errors++; $display("FAIL load_run_stall got %0b want 0", bus_if.core_stall_o); end
    checks++; if (bus_if.ld_ready_o !== 1'b0) begin errors++; $display("FAIL load_run_ready got %0b want 0", bus_if.ld_ready_o); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_m[i] !== 32'h1111_0000 + 32'(i)) begin
        errors++; $display("FAIL load_imem%0d got %h want %h", i, imem_m[i], 32'h1111_0000 + 32'(i)); end
    end
  endtask

  // core halts in its 40th RUN cycle with a store in the same cycle
  task automatic test_run_halt();
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      bus_if.core_inst_addr_i  = 32'(k * 4);
      bus_if.core_hlt_i        = (k == 39);
      bus_if.core_ldst_write_i = (k == 39);
      bus_if.core_ldst_addr_i  = 32'd7;
      bus_if.core_ldst_data_i  = 32'hCAFE_BABE;
      #1;
      checks++; if (bus_if.cycles_o !== 32'(k)) begin errors++; $display("FAIL run_cycles k%0d got %0d want %0d", k, bus_if.cycles_o, k); end
      if (k == 5) begin
        checks++; if (bus_if.imem_addr_o !== 32'd20 || bus_if.imem_write_o !== 1'b0) begin
          errors++; $display("FAIL run_imem got a=%0d we=%0b want a=20 we=0", bus_if.imem_addr_o, bus_if.imem_write_o); end
      end
      if (k == 39) begin
        checks++; if (bus_if.dmem_write_o !== 1'b1 || bus_if.dmem_addr_o !== 32'd7) begin
          errors++; $display("FAIL run_hlt_store got we=%0b a=%0d want we=1 a=7", bus_if.dmem_write_o, bus_if.dmem_addr_o); end
      end
    end
    @(negedge clk);
    bus_if.core_hlt_i = 1'b0;
    #1;
    checks++; if (bus_if.cycles_o !== 32'd40) begin errors++; $display("FAIL halt_cycles got %0d want 40", bus_if.cycles_o); end
    checks++; if (bus_if.timeout_o !== 1'b0) begin errors++; $display("FAIL halt_timeout got %0b want 0", bus_if.timeout_o); end
    checks++; if (bus_if.core_stall_o !== 1'b1) begin errors++; $display("FAIL halt_stall got %0b want 1", bus_if.core_stall_o); end
    checks++; if (bus_if.dmem_write_o !== 1'b0) begin errors++; $display("FAIL halt_store_ignored got %0b want 0", bus_if.dmem_write_o); end
    checks++; if (dmem_m[7] !== 32'hCAFE_BABE) begin errors++; $display("FAIL halt_store_mem got %h want cafebabe", dmem_m[7]); end
    bus_if.core_ldst_write_i = 1'b0;
  endtask

  // full dump, sink stalls three cycles on word 5
  task automatic test_dump_stall();
    int e;
    int hold;
    bit fin;
    e = 0; hold = 0; fin = 1'b0;
    bus_if.dump_ready_i = 1'b1;
    for (int c = 0; c < 1200 && !fin; c++) begin
      @(negedge clk);
      #1;
      if (bus_if.done_o === 1'b1) begin
        fin = 1'b1;
      end else if (bus_if.dump_valid_o === 1'b1) begin
        checks++; if (bus_if.dump_addr_o !== 32'(e) || bus_if.dump_data_o !== exp_d(e)) begin
          errors++; $display("FAIL dump_word got a=%0d d=%h want a=%0d d=%h", bus_if.dump_addr_o, bus_if.dump_data_o, e, exp_d(e)); end
        checks++; if (bus_if.dump_last_o !== (e == 255)) begin
          errors++; $display("FAIL dump_last a=%0d got %0b want %0b", e, bus_if.dump_last_o, (e == 255)); end
        if (e == 5 && hold < 3) begin
          bus_if.dump_ready_i = 1'b0;
          hold++;
        end else begin
          bus_if.dump_ready_i = 1'b1;
          e++;
        end
      end else begin
        bus_if.dump_ready_i = 1'b1;
      end
    end
    checks++; if (!fin) begin errors++; $display("FAIL dump_timeout got done=0 want done=1"); end
    checks++; if (e != 256 || hold != 3) begin errors++; $display("FAIL dump_count got words=%0d stalls=%0d want 256 3", e, hold); end
    @(negedge clk);
    bus_if.ld_valid_i = 1'b1;
    #1;
    checks++; if (bus_if.done_o !== 1'b1 || bus_if.dump_valid_o !== 1'b0 || bus_if.core_stall_o !== 1'b1) begin
      errors++; $display("FAIL done_state got done=%0b v=%0b st=%0b want 1 0 1", bus_if.done_o, bus_if.dump_valid_o, bus_if.core_stall_o); end
    checks++; if (bus_if.ld_ready_o !== 1'b0 || bus_if.imem_write_o !== 1'b0) begin
      errors++; $display("FAIL done_no_load got rdy=%0b we=%0b want 0 0", bus_if.ld_ready_o, bus_if.imem_write_o); end
    bus_if.ld_valid_i = 1'b0;
  endtask

  // no last flag: load ends on word 255
  task automatic test_load_full();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      bus_if.ld_valid_i = 1'b1;
      bus_if.ld_last_i  = 1'b0;
      bus_if.ld_data_i  = 32'hA000_0000 + 32'(i);
      #1;
      if (i == 255) begin
        checks++; if (bus_if.ld_ready_o !== 1'b1 || bus_if.imem_addr_o !== 32'd255) begin
          errors++; $display("FAIL full_last got rdy=%0b a=%0d want 1 255", bus_if.ld_ready_o, bus_if.imem_addr_o); end
      end
    end
    @(negedge clk);
    bus_if.ld_data_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus_if.ld_ready_o !== 1'b0 || bus_if.core_stall_o !== 1'b0) begin
      errors++; $display("FAIL full_run got rdy=%0b st=%0b want 0 0", bus_if.ld_ready_o, bus_if.core_stall_o); end
    checks++; if (bus_if.imem_write_o !== 1'b0) begin errors++; $display("FAIL full_no_write got %0b want 0", bus_if.imem_write_o); end
    checks++; if (imem_m[0] !== 32'hA000_0000 || imem_m[255] !== 32'hA000_00FF) begin
      errors++; $display("FAIL full_imem got %h %h want a0000000 a00000ff", imem_m[0], imem_m[255]); end
    bus_if.ld_valid_i = 1'b0;
  endtask

  // core never halts: forced dump after 50 RUN cycles
  task automatic test_timeout();
    int n;
    bit left;
    n = 1; left = 1'b0;
    bus_if.core_hlt_i = 1'b0;
    for (int c = 0; c < 200 && !left; c++) begin
      @(negedge clk);
      #1;
      if (bus_if.core_stall_o === 1'b0) n++;
      else left = 1'b1;
    end
    checks++; if (!left || n != 50) begin errors++; $display("FAIL timeout_run_len got %0d want 50", n); end
    checks++; if (bus_if.cycles_o !== 32'd50) begin errors++; $display("FAIL timeout_cycles got %0d want 50", bus_if.cycles_o); end
    checks++; if (bus_if.timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_flag got %0b want 1", bus_if.timeout_o); end
    checks++; if (bus_if.core_stall_o !== 1'b1) begin errors++; $display("FAIL timeout_stall got %0b want 1", bus_if.core_stall_o); end
  endtask

  // reset while word 10 is presented
  task automatic test_reset_mid_dump();
    bit hit;
    hit = 1'b0;
    bus_if.dump_ready_i = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      #1;
      if (bus_if.dump_valid_o === 1'b1 && bus_if.dump_addr_o === 32'd10) hit = 1'b1;
    end
    checks++; if (!hit || bus_if.dump_data_o !== exp_d(10)) begin
      errors++; $display("FAIL middump_word10 got hit=%0b d=%h want 1 %h", hit, bus_if.dump_data_o, exp_d(10)); end
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus_if.ld_ready_o !== 1'b1 || bus_if.core_stall_o !== 1'b1 || bus_if.dump_valid_o !== 1'b0) begin
      errors++; $display("FAIL middump_state got rdy=%0b st=%0b v=%0b want 1 1 0", bus_if.ld_ready_o, bus_if.core_stall_o, bus_if.dump_valid_o); end
    checks++; if (bus_if.cycles_o !== 32'd0 || bus_if.timeout_o !== 1'b0 || bus_if.dump_addr_o !== 32'd0 || bus_if.done_o !== 1'b0) begin
      errors++; $display("FAIL middump_counters got cyc=%0d to=%0b ptr=%0d done=%0b want 0 0 0 0", bus_if.cycles_o, bus_if.timeout_o, bus_if.dump_addr_o, bus_if.done_o); end
    reset = 1'b0;
  endtask

  // halt in the same cycle as the limit: halt wins
  task automatic test_halt_at_limit();
    @(negedge clk);
    bus_if.ld_valid_i = 1'b1;
    bus_if.ld_last_i  = 1'b1;
    bus_if.ld_data_i  = 32'h0000_0013;
    @(negedge clk);
    bus_if.ld_valid_i = 1'b0;
    bus_if.ld_last_i  = 1'b0;
    for (int k = 1; k < 50; k++) begin
      @(negedge clk);
      bus_if.core_hlt_i = (k == 49);
    end
    @(negedge clk);
    bus_if.core_hlt_i = 1'b0;
    #1;
    checks++; if (bus_if.cycles_o !== 32'd50) begin errors++; $display("FAIL limit_cycles got %0d want 50", bus_if.cycles_o); end
    checks++; if (bus_if.timeout_o !== 1'b0) begin errors++; $display("FAIL limit_halt_wins got %0b want 0", bus_if.timeout_o); end
    checks++; if (bus_if.core_stall_o !== 1'b1) begin errors++; $display("FAIL limit_stall got %0b want 1", bus_if.core_stall_o); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    init_mem = 1'b1;
    bus_if.ld_valid_i        = 1'b0;
    bus_if.ld_data_i         = '0;
    bus_if.ld_last_i         = 1'b0;
    bus_if.core_inst_addr_i  = '0;
    bus_if.core_hlt_i        = 1'b0;
    bus_if.core_ldst_addr_i  = '0;
    bus_if.core_ldst_write_i = 1'b0;
    bus_if.core_ldst_data_i  = '0;
    bus_if.dump_ready_i      = 1'b1;
    test_reset();
    test_load_gaps();
    test_run_halt();
    test_dump_stall();
    test_load_full();
    test_timeout();
    test_reset_mid_dump();
    test_halt_at_limit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
